// File: rtl/barramento_arbitrado.sv
// Shared-bus controller: round-robin request/grant arbitration with hold limit,
// turnaround bubble and registered bus mux. Optional macro: FONTE0_PRIORITARIA_EN.
module barramento_arbitrado #(
  parameter int N_FONTES  = 6,
  parameter int LARGURA   = 8,
  parameter int MAX_POSSE = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_FONTES-1:0]           req,
  input  logic [N_FONTES*LARGURA-1:0]   dado_in,
  output logic [N_FONTES-1:0]           grant,
  output logic [LARGURA-1:0]            barramento,
  output logic                          valido,
  output logic [$clog2(N_FONTES)-1:0]   dono
);

  localparam int IW = $clog2(N_FONTES);
  localparam int CW = (MAX_POSSE > 1) ? $clog2(MAX_POSSE) : 1;

`ifdef FONTE0_PRIORITARIA_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {OCIOSO, CONCEDIDO, TROCA} estado_t;

  estado_t         estado;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   g_idx;
  logic [CW-1:0]   cnt;
  logic            preempt;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   ptr_nxt;
  logic            others;

  // Round-robin search starting at ptr, wrapping at N_FONTES-1.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N_FONTES; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_FONTES) idx = idx - N_FONTES;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    ptr_nxt = (win == IW'(N_FONTES - 1)) ? '0 : win + IW'(1);
    others  = |(req & ~grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      grant      <= '0;
      barramento <= '0;
      valido     <= 1'b0;
      dono       <= '0;
      ptr        <= '0;
      g_idx      <= '0;
      cnt        <= '0;
      preempt    <= 1'b0;
    end else begin
      // Bus lags grant by one cycle; it holds its last value when nobody is granted.
      if (|grant) begin
        barramento <= dado_in[32'(g_idx)*LARGURA +: LARGURA];
        dono       <= g_idx;
        valido     <= 1'b1;
      end else begin
        valido     <= 1'b0;
      end

      case (estado)
        OCIOSO, TROCA: begin
          preempt <= 1'b0;
          cnt     <= '0;
          if (PRIO0 && estado == TROCA && preempt && req[0]) begin
            // Preemptive grant to source 0 leaves the rotation pointer untouched.
            grant  <= N_FONTES'(1);
            g_idx  <= '0;
            estado <= CONCEDIDO;
          end else if (found) begin
            grant  <= N_FONTES'(1) << win;
            g_idx  <= win;
            ptr    <= ptr_nxt;
            estado <= CONCEDIDO;
          end else begin
            grant  <= '0;
            estado <= OCIOSO;
          end
        end

        CONCEDIDO: begin
          if (!req[g_idx]) begin
            grant  <= '0;
            cnt    <= '0;
            estado <= others ? TROCA : OCIOSO;
          end else if (PRIO0 && g_idx != '0 && req[0]) begin
            grant   <= '0;
            cnt     <= '0;
            preempt <= 1'b1;
            estado  <= TROCA;
          end else if (cnt == CW'(MAX_POSSE - 1)) begin
            cnt <= '0;
            if (others) begin
              grant  <= '0;
              estado <= TROCA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          grant  <= '0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule
